muldiv_unit: RTL

Iterative RV32M/RV64M multiply/divide unit that extends the single-cycle ALU decode path with the M-extension operations. It sits beside the main ALU in the execute stage. It accepts one operation per `start` pulse and computes the result over multiple cycles. The hazard unit holds the pipeline while `busy` is high. Operand width is parametrised; the unit handles every M-extension `funct3` encoding, including the architecturally defined corner cases.

---
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake/operand bundle between the execute stage and the M-extension unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic            flush;
    logic [2:0]      func3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, func3, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, func3, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, one bit per RUN cycle, signs fixed up in a FIX cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_func3;
    logic            r_neg_a;
    logic            r_neg_b;
    logic            r_special;
    logic [XLEN-1:0] r_spec_val;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_result;
    logic            r_busy;
    logic            r_done;

    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_val;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_sub;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0] w_quo_s;
    logic [XLEN-1:0] w_rem_s;
    logic [XLEN-1:0] w_fix_val;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;

    // Operand decode on accept: sign flags, magnitudes and special-case results.
    always_comb begin
        w_a_signed = (bus.func3 == 3'b001) || (bus.func3 == 3'b010) ||
                     (bus.func3 == 3'b100) || (bus.func3 == 3'b110);
        w_b_signed = (bus.func3 == 3'b001) || (bus.func3 == 3'b100) ||
                     (bus.func3 == 3'b110);
        w_neg_a    = w_a_signed && bus.a[XLEN-1];
        w_neg_b    = w_b_signed && bus.b[XLEN-1];
        w_mag_a    = w_neg_a ? -bus.a : bus.a;
        w_mag_b    = w_neg_b ? -bus.b : bus.b;
        w_div0     = bus.func3[2] && (bus.b == '0);
        w_ovf      = bus.func3[2] && !bus.func3[0] && (bus.a == SMIN) && (bus.b == '1);
        w_special  = w_div0 || w_ovf;
        w_spec_val = '0;
        if (w_div0)
            w_spec_val = bus.func3[1] ? bus.a : '1;
        else if (w_ovf)
            w_spec_val = bus.func3[1] ? '0 : bus.a;
    end

    // One iteration step of the shift-add multiplier and restoring divider.
    always_comb begin
        w_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_shift = {r_rem, r_quo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_div});
        w_sub   = w_shift[XLEN-1:0] - r_div;
    end

    // Sign correction and result selection used in the FIX cycle.
    always_comb begin
        w_prod_s  = (r_neg_a ^ r_neg_b) ? -r_prod : r_prod;
        w_quo_s   = (r_neg_a ^ r_neg_b) ? -r_quo : r_quo;
        w_rem_s   = r_neg_a ? -r_rem : r_rem;
        w_fix_val = '0;
        if (r_special)
            w_fix_val = r_spec_val;
        else if (r_func3 == 3'b000)
            w_fix_val = w_prod_s[XLEN-1:0];
        else if (!r_func3[2])
            w_fix_val = w_prod_s[2*XLEN-1:XLEN];
        else if (!r_func3[1])
            w_fix_val = w_quo_s;
        else
            w_fix_val = w_rem_s;
    end

    // Next-state logic; flush overrides every transition out of a busy state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_FIX : S_RUN;
            S_RUN:  if (r_cnt == CW'(XLEN - 1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush && (r_state != S_IDLE))
            w_next = S_IDLE;
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
        end
    end

    // Datapath: load on accept, iterate in RUN, capture result leaving FIX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_func3    <= '0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_prod     <= '0;
            r_mcand    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_result   <= '0;
        end else begin
            if (w_accept) begin
                r_cnt      <= '0;
                r_func3    <= bus.func3;
                r_neg_a    <= w_neg_a;
                r_neg_b    <= w_neg_b;
                r_special  <= w_special;
                r_spec_val <= w_spec_val;
                r_prod     <= {{XLEN{1'b0}}, w_mag_b};
                r_mcand    <= w_mag_a;
                r_quo      <= w_mag_a;
                r_rem      <= '0;
                r_div      <= w_mag_b;
            end else if (r_state == S_RUN) begin
                r_cnt  <= r_cnt + 1'b1;
                r_prod <= {w_sum, r_prod[XLEN-1:1]};
                r_quo  <= {r_quo[XLEN-2:0], w_ge};
                r_rem  <= w_ge ? w_sub : w_shift[XLEN-1:0];
            end
            if ((r_state == S_FIX) && !bus.flush)
                r_result <= w_fix_val;
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule
